// File: rtl/coalesce_pkg.sv
// Shared constants and state encoding for the warp memory coalescer.
package coalesce_pkg;

    localparam int THREADS  = 32;
    localparam int ADDR_W   = 32;
    localparam int SEG_LSB  = 7;
    localparam int SEGNUM_W = 5;
    localparam int TAG_W    = ADDR_W - SEG_LSB;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } coal_state_e;

endpackage

// File: rtl/coalesce_pick.sv
// Combinational segment picker: lowest pending thread selects the segment tag,
// and every pending thread in that same segment is flagged in match_o.
module coalesce_pick
    import coalesce_pkg::*;
(
    input  logic [THREADS-1:0]        pend_i,
    input  logic [THREADS*ADDR_W-1:0] addr_i,
    output logic [SEGNUM_W-1:0]       pick_o,
    output logic [TAG_W-1:0]          tag_o,
    output logic [THREADS-1:0]        match_o
);

    logic [ADDR_W-1:0] addr_a [THREADS];

    always_comb begin
        for (int k = 0; k < THREADS; k++) begin
            addr_a[k] = addr_i[k*ADDR_W +: ADDR_W];
        end
    end

    // Scanning downward leaves the lowest set index as the final winner.
    always_comb begin
        pick_o = '0;
        for (int k = THREADS - 1; k >= 0; k--) begin
            if (pend_i[k]) begin
                pick_o = SEGNUM_W'(k);
            end
        end
    end

    assign tag_o = addr_a[pick_o][ADDR_W-1:SEG_LSB];

    always_comb begin
        match_o = '0;
        for (int k = 0; k < THREADS; k++) begin
            match_o[k] = pend_i[k] && (addr_a[k][ADDR_W-1:SEG_LSB] == tag_o);
        end
    end

endmodule

// File: rtl/coalesce_unit.sv
// Warp memory coalescer: merges active threads sharing a 128 B segment and
// issues one segment address per unstalled cycle toward the L1 tag stage.
module coalesce_unit
    import coalesce_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [THREADS-1:0]        req_mask,
    input  logic [THREADS*ADDR_W-1:0] req_addr,
    input  logic                      stall,
    output logic [ADDR_W-1:0]         Coalesce2L1_o,
    output logic [SEGNUM_W-1:0]       SegNum,
    output logic                      Coal_valid,
    output logic                      Coal_last,
    output coal_state_e               dbg_state_o
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high exactly while the FSM is idle.
    // The output slot advances only when it is empty or stall is low.

    coal_state_e               state_q, state_d;
    logic [THREADS-1:0]        pend_q, pend_d;
    logic [THREADS*ADDR_W-1:0] addr_q;
    logic [SEGNUM_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]         oaddr_q, oaddr_d;
    logic [SEGNUM_W-1:0]       seg_q, seg_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;

    logic                      accept;
    logic                      slot_free;
    logic                      load;
    logic [SEGNUM_W-1:0]       pick;
    logic [TAG_W-1:0]          tag;
    logic [THREADS-1:0]        match;
    logic [THREADS-1:0]        rest;

    coalesce_pick u_pick (
        .pend_i  (pend_q),
        .addr_i  (addr_q),
        .pick_o  (pick),
        .tag_o   (tag),
        .match_o (match)
    );

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign slot_free = !valid_q || !stall;
    assign load      = (state_q == ST_EMIT) && slot_free;
    assign rest      = pend_q & ~match;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        oaddr_d = oaddr_q;
        seg_d   = seg_q;
        valid_d = valid_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pend_d = req_mask;
                    cnt_d  = '0;
                    if (req_mask != '0) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (slot_free) begin
                    oaddr_d = {tag, {SEG_LSB{1'b0}}};
                    seg_d   = cnt_q;
                    valid_d = 1'b1;
                    last_d  = (rest == '0);
                    pend_d  = rest;
                    // Hold the counter on the final segment so it never wraps.
                    if (rest == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!load && !stall) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
            oaddr_q <= '0;
            seg_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            oaddr_q <= oaddr_d;
            seg_q   <= seg_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign Coalesce2L1_o = oaddr_q;
    assign SegNum        = seg_q;
    assign Coal_valid    = valid_q;
    assign Coal_last     = last_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_coalesce_unit.sv
// Self-checking bench for coalesce_unit: directed cases plus randomised
// requests with random stall, checked through an expected-segment queue.
module tb_coalesce_unit;
    import coalesce_pkg::*;

    localparam int OW = ADDR_W + SEGNUM_W + 1;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      req_valid = 1'b0;
    logic                      req_ready;
    logic [THREADS-1:0]        req_mask = '0;
    logic [THREADS*ADDR_W-1:0] req_addr = '0;
    logic                      stall = 1'b0;
    logic [ADDR_W-1:0]         Coalesce2L1_o;
    logic [SEGNUM_W-1:0]       SegNum;
    logic                      Coal_valid;
    logic                      Coal_last;
    coal_state_e               dbg_state_o;

    logic [OW-1:0]     exp_q[$];
    logic [ADDR_W-1:0] ta [THREADS];
    int                n_checks = 0;
    int                n_bad = 0;

    coalesce_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mask      (req_mask),
        .req_addr      (req_addr),
        .stall         (stall),
        .Coalesce2L1_o (Coalesce2L1_o),
        .SegNum        (SegNum),
        .Coal_valid    (Coal_valid),
        .Coal_last     (Coal_last),
        .dbg_state_o   (dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Segment consumed on the next rising edge when valid and not stalled.
    always @(negedge clk) begin
        if (reset && Coal_valid && !stall) begin
            if (exp_q.size() == 0) begin
                check("extra_seg", {63'b0, Coal_valid}, 64'd0);
            end else begin
                check("seg", {Coalesce2L1_o, SegNum, Coal_last}, exp_q.pop_front());
            end
        end
    end

    task automatic model_push(input logic [THREADS-1:0] mask);
        logic [THREADS-1:0] pend;
        logic [THREADS-1:0] m;
        logic [TAG_W-1:0]   s;
        int                 n;
        int                 p;
        pend = mask;
        n = 0;
        while (pend != '0) begin
            p = 0;
            while (!pend[p]) p++;
            s = ta[p][ADDR_W-1:SEG_LSB];
            m = '0;
            for (int k = 0; k < THREADS; k++) begin
                if (pend[k] && ta[k][ADDR_W-1:SEG_LSB] == s) m[k] = 1'b1;
            end
            pend = pend & ~m;
            exp_q.push_back({s, {SEG_LSB{1'b0}}, SEGNUM_W'(n), pend == '0});
            n++;
        end
    endtask

    task automatic send(input logic [THREADS-1:0] mask);
        int guard;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_send", {63'b0, req_ready}, 64'd1);
        model_push(mask);
        for (int k = 0; k < THREADS; k++) req_addr[k*ADDR_W +: ADDR_W] = ta[k];
        req_mask  = mask;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget, input bit rnd_stall, output int cycles);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || Coal_valid) && c < budget) begin
            if (rnd_stall) stall = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            c++;
        end
        stall = 1'b0;
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        cycles = c;
    endtask

    task automatic load_stride();
        for (int k = 0; k < THREADS; k++) ta[k] = 32'h1000 + 32'(128 * k);
    endtask

    initial begin
        int c;
        int guard;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'b0, Coal_valid}, 64'd0);
        check("rst_last", {63'b0, Coal_last}, 64'd0);
        check("rst_addr", 64'(Coalesce2L1_o), 64'd0);
        check("rst_seg", 64'(SegNum), 64'd0);
        check("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", {63'b0, req_ready}, 64'd1);

        // Test 1: all threads in one segment.
        for (int k = 0; k < THREADS; k++) ta[k] = 32'hAAAAAA80 + 32'(4 * k);
        send('1);
        check("t1_busy", {63'b0, req_ready}, 64'd0);
        check("t1_not_yet", {63'b0, Coal_valid}, 64'd0);
        @(posedge clk); #1;
        check("t1_valid", {63'b0, Coal_valid}, 64'd1);
        check("t1_addr", 64'(Coalesce2L1_o), 64'hAAAAAA80);
        check("t1_last", {63'b0, Coal_last}, 64'd1);
        check("t1_ready", {63'b0, req_ready}, 64'd1);
        drain("t1", 20, 1'b0, c);

        // Test 2: 32 distinct segments, one per cycle with no gap.
        load_stride();
        send('1);
        drain("t2", 100, 1'b0, c);
        check("t2_cycles", 64'(c), 64'd33);

        // Test 3: two sparse threads in different segments.
        for (int k = 0; k < THREADS; k++) ta[k] = $urandom;
        ta[0] = 32'hAAAAAAAA;
        ta[2] = 32'hAAAAABEA;
        send(32'h5);
        @(posedge clk); #1;
        check("t3_first", 64'(Coalesce2L1_o), 64'hAAAAAA80);
        @(posedge clk); #1;
        check("t3_second", {32'b0, Coalesce2L1_o}, 64'hAAAAAB80);
        check("t3_last", {63'b0, Coal_last}, 64'd1);
        drain("t3", 20, 1'b0, c);

        // Test 4: three-cycle stall while segment 4 is presented.
        load_stride();
        send('1);
        guard = 0;
        while (!(Coal_valid && SegNum == 5'd4) && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t4_reach", {63'b0, Coal_valid && SegNum == 5'd4}, 64'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t4_hold_addr", 64'(Coalesce2L1_o), 64'h1200);
            check("t4_hold_seg", 64'(SegNum), 64'd4);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        check("t4_resume_addr", 64'(Coalesce2L1_o), 64'h1280);
        check("t4_resume_seg", 64'(SegNum), 64'd5);
        drain("t4", 100, 1'b0, c);
        check("t4_cycles", 64'(c), 64'd27);

        // Test 5: empty mask is accepted and dropped.
        send('0);
        check("t5_ready", {63'b0, req_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t5_quiet", {63'b0, Coal_valid}, 64'd0);
        end

        // Test 6: reset in the middle of a request.
        load_stride();
        send('1);
        guard = 0;
        while (!(Coal_valid && SegNum == 5'd10) && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t6_reach", {63'b0, Coal_valid && SegNum == 5'd10}, 64'd1);
        reset = 1'b0;
        #1;
        check("t6_valid", {63'b0, Coal_valid}, 64'd0);
        check("t6_seg", 64'(SegNum), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_ready", {63'b0, req_ready}, 64'd1);
        for (int k = 0; k < THREADS; k++) ta[k] = 32'h2000 + 32'(128 * (k % 3));
        send('1);
        @(posedge clk); #1;
        check("t6_restart_seg", 64'(SegNum), 64'd0);
        drain("t6", 40, 1'b0, c);

        // Randomised requests over a handful of segments with random stall.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < THREADS; k++) begin
                ta[k] = 32'h40000000 + (32'($urandom_range(0, 5)) << SEG_LSB) + 32'($urandom_range(0, 127));
            end
            send($urandom);
            drain("rnd", 400, 1'b1, c);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
